// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    // One-hot result encoding ordered {L, E, G}; all-zero means "no result yet".
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_L    = 3'b100;
    localparam logic [2:0] RES_E    = 3'b010;
    localparam logic [2:0] RES_G    = 3'b001;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// Combinational CHUNK-bit less/equal/greater comparator, one-hot {L,E,G} result.
module comparator_slice
    import cmp_pkg::*;
#(
    parameter int CHUNK = 3
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic [2:0]       res_o
);

    always_comb begin
        res_o = RES_E;
        if (a_i > b_i) begin
            res_o = RES_G;
        end else if (a_i < b_i) begin
            res_o = RES_L;
        end
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with START/BUSY/DONE handshake.
// Optional CMP_EARLY_EXIT_EN ends the operation at the first differing chunk.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int CHUNK  = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             l_o,
    output logic             e_o,
    output logic             g_o
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       diff_q, diff_d;
    logic [2:0]       res_q, res_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             load;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic [2:0]       cur_res;
    logic [2:0]       first_res;
    logic             last_step;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
        chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
        if (SIGNED && (idx_q == IDX_TOP)) begin
            chunk_a = chunk_a ^ MSB_MASK;
            chunk_b = chunk_b ^ MSB_MASK;
        end
    end

    comparator_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i   (chunk_a),
        .b_i   (chunk_b),
        .res_o (cur_res)
    );

    always_comb begin
        first_res = (diff_q == RES_E) ? cur_res : diff_q;
`ifdef CMP_EARLY_EXIT_EN
        last_step = (idx_q == '0) || (cur_res != RES_E);
`else
        last_step = (idx_q == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        res_d   = res_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COMPARE;
                    idx_d   = IDX_TOP;
                    diff_d  = RES_E;
                    load    = 1'b1;
                end
            end
            COMPARE: begin
                diff_d = first_res;
                if (last_step) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    res_d   = first_res;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            diff_q  <= RES_E;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    // Operand shadows carry no reset: they are only read while in COMPARE.
    always_ff @(posedge clk_i) begin
        if (load) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    assign busy_o = (state_q == COMPARE);
    assign done_o = done_q;
    assign l_o    = res_q[2];
    assign e_o    = res_q[1];
    assign g_o    = res_q[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=12, CHUNK=3), unsigned and signed instances.
module tb_seq_magnitude_comparator;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] XL = 3'b100;
    localparam logic [2:0] XE = 3'b010;
    localparam logic [2:0] XG = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] a = '0;
    logic [11:0] b = '0;
    logic        busy_u, done_u, l_u, e_u, g_u;
    logic        busy_s, done_s, l_s, e_s, g_s;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(12), .CHUNK(3), .SIGNED(1'b0)) dut_u (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy_u), .done_o(done_u), .l_o(l_u), .e_o(e_u), .g_o(g_u)
    );

    seq_magnitude_comparator #(.WIDTH(12), .CHUNK(3), .SIGNED(1'b1)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy_s), .done_o(done_s), .l_o(l_s), .e_o(e_s), .g_o(g_s)
    );

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [2:0]  exp_u;
        logic [2:0]  exp_s;
        int          pos;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_lat(input int pos);
        return EARLY ? pos + 1 : 4;
    endfunction

    // Accept an operation and count cycles until DONE (bounded).
    task automatic run_op(input logic [11:0] av, input logic [11:0] bv, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", int'(busy_u), 1);
        lat = 0;
        while (!done_u && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{12'h000, 12'h000, XE, XE, 3};
        vecs[1] = '{12'h800, 12'h400, XG, XL, 0};
        vecs[2] = '{12'h001, 12'h002, XL, XL, 3};
        vecs[3] = '{12'h002, 12'h001, XG, XG, 3};
        vecs[4] = '{12'hFFF, 12'h001, XG, XL, 0};
        vecs[5] = '{12'h123, 12'h123, XE, XE, 3};
        vecs[6] = '{12'h0A5, 12'h0C5, XL, XL, 1};
        vecs[7] = '{12'h7FF, 12'h800, XL, XG, 0};
        vecs[8] = '{12'h456, 12'h455, XG, XG, 3};

        #1;
        chk("por_busy", int'(busy_u), 0);
        chk("por_done", int'(done_u), 0);
        chk("por_flags", int'({l_u, e_u, g_u}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].pos));
            chk($sformatf("v%0d_busy_at_done", i), int'(busy_u), 0);
            chk($sformatf("v%0d_unsigned", i), int'({l_u, e_u, g_u}), int'(vecs[i].exp_u));
            chk($sformatf("v%0d_signed", i), int'({l_s, e_s, g_s}), int'(vecs[i].exp_s));
            chk($sformatf("v%0d_signed_done", i), int'(done_s), 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), int'(done_u), 0);
            chk($sformatf("v%0d_hold", i), int'({l_u, e_u, g_u}), int'(vecs[i].exp_u));
        end

        // START accepted in the DONE cycle of the previous operation.
        run_op(12'h001, 12'h002, lat);
        chk("b2b_first_lat", lat, 4);
        chk("b2b_first_res", int'({l_u, e_u, g_u}), int'(XL));
        run_op(12'h002, 12'h001, lat);
        chk("b2b_second_lat", lat, 4);
        chk("b2b_second_res", int'({l_u, e_u, g_u}), int'(XG));

        // START pulses while BUSY are ignored.
        @(negedge clk);
        a = 12'h001;
        b = 12'h002;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 12'hFFF;
        b = 12'h000;
        lat = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        while (!done_u && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ignored_start_lat", lat, 4);
        chk("ignored_start_res", int'({l_u, e_u, g_u}), int'(XL));
        @(posedge clk);
        #1;
        chk("ignored_start_no_requeue", int'(busy_u), 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a = 12'h001;
        b = 12'h002;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_reset_flags", int'({l_u, e_u, g_u}), int'(XL));
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy_u), 0);
        chk("async_rst_done", int'(done_u), 0);
        chk("async_rst_flags", int'({l_u, e_u, g_u}), 0);
        chk("async_rst_flags_s", int'({l_s, e_s, g_s}), 0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done_u || busy_u) lat++;
        end
        chk("no_done_after_reset", lat, 0);

        run_op(12'hFFF, 12'h001, lat);
        chk("post_reset_lat", lat, exp_lat(0));
        chk("post_reset_unsigned", int'({l_u, e_u, g_u}), int'(XG));
        chk("post_reset_signed", int'({l_s, e_s, g_s}), int'(XL));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Multi-cycle, parametrised magnitude comparator that generalises the team's 3-bit combinational L/E/G comparator to arbitrary operand widths. It compares operands MSB-first, CHUNK bits per clock, and returns registered less/equal/greater flags under a START/BUSY/DONE handshake. It sits beside the datapath wherever wide compares must not load the critical path, such as threshold checks and sort/min-max units.

## Interface
- WIDTH, 12: operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 3: bits compared per cycle; NCHUNK = WIDTH/CHUNK ≥ 1.
- SIGNED, 0: 0 = unsigned compare; 1 = two's-complement compare.
- CLK  in  1: clock; all state updates on rising edge.
- RST  in  1: asynchronous, active-high reset.
- START  in  1: request; sampled only when BUSY=0.
- A  in  WIDTH: operand A; sampled on the accepting edge.
- B  in  WIDTH: operand B; sampled on the accepting edge.
- BUSY  out  1: comparison in progress.
- DONE  out  1: one-cycle pulse; L/E/G are updated on the same edge.
- L  out  1: A < B.
- E  out  1: A == B.
- G  out  1: A > B.

## Operation
- The FSM has two states: IDLE and COMPARE.
- IDLE, START=1:
  - Latch A and B into shadow registers.
  - Set chunk index idx = NCHUNK-1.
  - Go to COMPARE; BUSY=1.
- COMPARE, each cycle:
  - Compare shadow chunk [idx*CHUNK +: CHUNK] of A against the same chunk of B.
  - When SIGNED=1, invert the operand MSBs before comparing the top chunk.
  - The first differing chunk fixes the result as L or G; later chunks cannot change it.
  - The final step ends the operation: go to IDLE, BUSY=0, pulse DONE, load L/E/G.
  - If no chunk differs, the result is E=1.
  - Otherwise idx decrements.
- At most one of L/E/G is 1 at any time.
- L/E/G hold until the next DONE.
- START while BUSY=1 is ignored; no queueing.
- A and B may change after acceptance without affecting the result.
- Reset, including mid-operation:
  - State returns to IDLE; BUSY=0, DONE=0, L=E=G=0.
  - The in-flight comparison is discarded and no DONE is produced.

## Timing
- START is accepted at edge t.
- Full-length operation: DONE, L, E and G become valid at edge t+NCHUNK; DONE is high for exactly one cycle.
- BUSY is high from edge t up to the DONE edge.
- BUSY is low during the DONE cycle, so START is accepted in that cycle. Back-to-back throughput is one result per NCHUNK cycles.
- NCHUNK=1: DONE at t+1.

## Configuration
- `CMP_EARLY_EXIT_EN` defined:
  - The final step is the first differing chunk.
  - If the differing chunk is p positions below the top (top = 0), DONE is at edge t+p+1.
  - Equality always takes NCHUNK cycles.
- `CMP_EARLY_EXIT_EN` undefined:
  - Latency is fixed at NCHUNK cycles regardless of data (constant-time).
  - A result flag holds the first difference until idx = 0.

## Structure
- Package cmp_pkg contains:
  - state enum {IDLE, COMPARE};
  - result encoding constants RES_L, RES_E, RES_G;
  - a function computing NCHUNK and the idx width ($clog2(NCHUNK), minimum 1).
- Sub-module comparator_slice is a combinational CHUNK-bit L/E/G comparator. It is the existing 3-bit comparator function generalised to CHUNK bits, and is instantiated once on the idx-selected chunk.
- Top level contains the FSM, shadow registers, idx counter and output registers.

## Test plan
All cases use WIDTH=12, CHUNK=3.

- Reset: assert RST asynchronously mid-cycle → BUSY=0, DONE=0, L=E=G=0 immediately, without waiting for a clock edge.
- A=12'h000, B=12'h000, START → DONE at t+4, E=1, L=G=0; BUSY high for 4 cycles.
- A=12'h800, B=12'h400, SIGNED=0 → G=1. DONE at t+1 with `CMP_EARLY_EXIT_EN`; DONE at t+4 without it.
- A=12'h001, B=12'h002 → L=1, DONE at t+4 in both configurations. Then START in the DONE cycle with A=12'h002, B=12'h001 → accepted, G=1 at the next DONE.
- SIGNED=1: A=12'hFFF (-1), B=12'h001 → L=1. SIGNED=0 with the same operands → G=1.
- START pulses at t+1 and t+2 with new operands while BUSY → ignored, result reflects the operands latched at t. RST asserted at t+2 → no DONE, outputs 0, next START behaves normally.
